// File: rtl/sample_frame_streamer.sv
// Buffers multi-channel ADC sample sets and streams each one as a byte frame to a UART.
// Build option STREAM_HEX_EN selects ASCII hex framing instead of binary sync framing.
module sample_frame_streamer #(
   parameter int         CHANNELS   = 2,
   parameter int         SAMPLE_W   = 14,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             sample_valid,
   input  logic [CHANNELS*SAMPLE_W-1:0]     sample_data,
   input  logic                             tx_busy,
   output logic                             tx_start,
   output logic [7:0]                       tx_data,
   output logic                             overflow,
   input  logic                             clear_ovf,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

   localparam int SET_W = CHANNELS * SAMPLE_W;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = $clog2(FIFO_DEPTH + 1);
`ifdef STREAM_HEX_EN
   localparam int NBYTES = 5 * CHANNELS + 1;
`else
   localparam int NBYTES = 1 + 2 * CHANNELS;
`endif
   localparam int IW = $clog2(NBYTES + 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

   state_t           state_reg;
   logic [IW-1:0]    byte_idx_reg;
   logic [1:0]       guard_cnt_reg;
   logic [SET_W-1:0] frame_reg;
   logic             tx_start_reg;
   logic [7:0]       tx_data_reg;
   logic             overflow_reg;

   logic [SET_W-1:0] mem [FIFO_DEPTH];
   logic [LW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic             empty, full, pop, push, drop;

   // Extra pointer MSB tells full from empty when the address bits match.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[LW-1] != rd_ptr_reg[LW-1]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop   = (state_reg == IDLE) && !empty;
   assign push  = sample_valid && (!full || pop);
   assign drop  = sample_valid && full && !pop;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg[AW-1:0]] <= sample_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + LW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + LW'(1);
         if (drop)
            overflow_reg <= 1'b1;
         else if (clear_ovf)
            overflow_reg <= 1'b0;
      end
   end

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      hex_char = (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
   endfunction

   // While idle the next byte comes from the FIFO head, otherwise from the frame register.
   logic [SET_W-1:0] src_set;
   logic [15:0]      word [CHANNELS];
   logic [7:0]       frame_bytes [NBYTES];

   assign src_set = (state_reg == IDLE) ? mem[rd_ptr_reg[AW-1:0]] : frame_reg;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         assign word[gi] = 16'($signed(src_set[gi*SAMPLE_W +: SAMPLE_W]));
`ifdef STREAM_HEX_EN
         assign frame_bytes[5*gi]   = hex_char(word[gi][15:12]);
         assign frame_bytes[5*gi+1] = hex_char(word[gi][11:8]);
         assign frame_bytes[5*gi+2] = hex_char(word[gi][7:4]);
         assign frame_bytes[5*gi+3] = hex_char(word[gi][3:0]);
         assign frame_bytes[5*gi+4] = (gi == CHANNELS - 1) ? 8'h0D : 8'h2C;
`else
         assign frame_bytes[2*gi+1] = word[gi][15:8];
         assign frame_bytes[2*gi+2] = word[gi][7:0];
`endif
      end
   endgenerate

`ifdef STREAM_HEX_EN
   assign frame_bytes[NBYTES-1] = 8'h0A;
`else
   assign frame_bytes[0] = SYNC_BYTE;
`endif

   logic [IW-1:0] sel_idx;
   logic [7:0]    byte_next;

   always_comb begin
      sel_idx   = (state_reg == IDLE) ? '0 : byte_idx_reg + IW'(1);
      byte_next = 8'h00;
      for (int i = 0; i < NBYTES; i++)
         if (sel_idx == IW'(i))
            byte_next = frame_bytes[i];
   end

   // tx_start/tx_data are loaded on entry to SEND so the pulse coincides with SEND.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         byte_idx_reg  <= '0;
         guard_cnt_reg <= '0;
         frame_reg     <= '0;
         tx_start_reg  <= 1'b0;
         tx_data_reg   <= 8'h00;
      end else begin
         tx_start_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (!empty) begin
                  frame_reg    <= mem[rd_ptr_reg[AW-1:0]];
                  byte_idx_reg <= '0;
                  tx_start_reg <= 1'b1;
                  tx_data_reg  <= byte_next;
                  state_reg    <= SEND;
               end
            end
            SEND: begin
               guard_cnt_reg <= '0;
               state_reg     <= WAIT_ACK;
            end
            WAIT_ACK: begin
               // A busy that never rises must not stall the stream.
               if (tx_busy || guard_cnt_reg == 2'd3)
                  state_reg <= WAIT_DONE;
               else
                  guard_cnt_reg <= guard_cnt_reg + 2'd1;
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (byte_idx_reg == IW'(NBYTES - 1)) begin
                     state_reg <= IDLE;
                  end else begin
                     byte_idx_reg <= byte_idx_reg + IW'(1);
                     tx_start_reg <= 1'b1;
                     tx_data_reg  <= byte_next;
                     state_reg    <= SEND;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign tx_start   = tx_start_reg;
   assign tx_data    = tx_data_reg;
   assign overflow   = overflow_reg;
   assign fifo_level = wr_ptr_reg - rd_ptr_reg;

endmodule
